// File: rtl/boothr4_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and recoder select codes.
package boothr4_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_Q = 3'd1,
    LOAD_M = 3'd2,
    CALC   = 3'd3,
    OUT_LO = 3'd4,
    OUT_HI = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } sel_e;

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth digit recoder: maps {Q[1],Q[0],q_1} to the partial-product select.
module booth_r4_recoder
  import boothr4_pkg::*;
(
  input  logic [2:0] bits_i,
  output sel_e       sel_o
);

  always_comb begin
    sel_o = ZERO;
    case (bits_i)
      3'b001, 3'b010: sel_o = PM;
      3'b011:         sel_o = P2M;
      3'b100:         sel_o = N2M;
      3'b101, 3'b110: sel_o = NM;
      default:        sel_o = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential signed radix-4 Booth multiplier with byte-wide operand/result buses.
// Build option: BOOTHR4_HOLD_RESULT_EN keeps the high result byte on outbus while idle.
//
// state  | meaning
// IDLE   | waiting for beginsig; outbus idle value, endsig low
// WAIT_Q | waiting for locksig to capture multiplier Q
// LOAD_M | capture multiplicand M, clear step counter
// CALC   | one radix-4 add/shift step per cycle, WIDTH/2 steps
// OUT_LO | drive low product byte
// OUT_HI | drive high product byte with endsig
module booth_radix4_mult
  import boothr4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beginsig,
  input  logic             locksig,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             endsig
);

  localparam int STEPS = WIDTH / 2;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam int AW    = WIDTH + 2;

  state_e           state_q, state_d;
  logic [AW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             end_q, end_d;

  sel_e          sel;
  logic [AW-1:0] m_ext, m2_ext, addend, a_sum;

  booth_r4_recoder u_recoder (
    .bits_i ({q_q[1:0], q1_q}),
    .sel_o  (sel)
  );

  assign m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
  assign m2_ext = m_ext << 1;

  always_comb begin
    addend = '0;
    case (sel)
      PM:      addend = m_ext;
      P2M:     addend = m2_ext;
      NM:      addend = -m_ext;
      N2M:     addend = -m2_ext;
      default: addend = '0;
    endcase
  end

  assign a_sum = a_q + addend;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    end_d   = 1'b0;
    case (state_q)
      IDLE: begin
`ifndef BOOTHR4_HOLD_RESULT_EN
        out_d = '0;
`endif
        if (beginsig) state_d = WAIT_Q;
      end
      WAIT_Q: begin
        if (locksig) begin
          q_d     = inbus;
          a_d     = '0;
          q1_d    = 1'b0;
`ifdef BOOTHR4_HOLD_RESULT_EN
          out_d   = '0;
`endif
          state_d = LOAD_M;
        end
      end
      LOAD_M: begin
        m_d     = inbus;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        // Arithmetic shift of {A,Q,q_1} right by two after the add
        a_d   = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
        q_d   = {a_sum[1:0], q_q[WIDTH-1:2]};
        q1_d  = q_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) state_d = OUT_LO;
      end
      OUT_LO: begin
        out_d   = q_q;
        state_d = OUT_HI;
      end
      OUT_HI: begin
        out_d   = a_q[WIDTH-1:0];
        end_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      end_q   <= end_d;
    end
  end

  assign outbus = out_q;
  assign endsig = end_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench for booth_radix4_mult (WIDTH=8) against an integer-multiply reference.
module tb_booth_radix4_mult;

  logic       clk = 1'b0;
  logic       rst;
  logic       beginsig;
  logic       locksig;
  logic [7:0] inbus;
  logic [7:0] outbus;
  logic       endsig;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] idle_exp;

  booth_radix4_mult #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .beginsig (beginsig),
    .locksig  (locksig),
    .inbus    (inbus),
    .outbus   (outbus),
    .endsig   (endsig)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; dly = idle edges with locksig low, poke = beginsig pulse mid-CALC.
  task automatic run_op(input logic [7:0] q, input logic [7:0] m, input int dly, input bit poke);
    int          pr;
    logic [15:0] p;
    pr = $signed(q) * $signed(m);
    p  = pr[15:0];
    beginsig = 1'b1;
    step();
    beginsig = 1'b0;
    for (int i = 0; i < dly; i++) begin
      locksig = 1'b0;
      inbus   = 8'($urandom);
      step();
      chk("wait_endsig", {15'd0, endsig}, 16'd0);
      chk("wait_outbus", {8'd0, outbus}, {8'd0, idle_exp});
    end
    locksig = 1'b1;
    inbus   = q;
    step();
`ifdef BOOTHR4_HOLD_RESULT_EN
    idle_exp = 8'h00;
`endif
    locksig = 1'b0;
    inbus   = m;
    step();
    inbus = 8'($urandom);
    for (int s = 0; s < 4; s++) begin
      if (poke && s == 1) beginsig = 1'b1;
      step();
      beginsig = 1'b0;
      chk("calc_endsig", {15'd0, endsig}, 16'd0);
      chk("calc_outbus", {8'd0, outbus}, {8'd0, idle_exp});
    end
    step();
    chk("lo_byte", {8'd0, outbus}, {8'd0, p[7:0]});
    chk("lo_endsig", {15'd0, endsig}, 16'd0);
    step();
    chk("hi_byte", {8'd0, outbus}, {8'd0, p[15:8]});
    chk("hi_endsig", {15'd0, endsig}, 16'd1);
`ifdef BOOTHR4_HOLD_RESULT_EN
    idle_exp = p[15:8];
`else
    idle_exp = 8'h00;
`endif
    step();
    chk("idle_endsig", {15'd0, endsig}, 16'd0);
    chk("idle_outbus", {8'd0, outbus}, {8'd0, idle_exp});
    step();
    chk("idle2_endsig", {15'd0, endsig}, 16'd0);
  endtask

  initial begin
    rst      = 1'b1;
    beginsig = 1'b0;
    locksig  = 1'b0;
    inbus    = 8'h00;
    idle_exp = 8'h00;
    @(negedge clk);
    step();
    step();
    chk("rst_outbus", {8'd0, outbus}, 16'd0);
    chk("rst_endsig", {15'd0, endsig}, 16'd0);
    rst = 1'b0;
    step();

    run_op(8'hD3, 8'h45, 0, 1'b0);
    run_op(8'h80, 8'h80, 0, 1'b0);
    run_op(8'h7F, 8'h7F, 1, 1'b0);
    run_op(8'h00, 8'hFF, 0, 1'b0);
    run_op(8'hFF, 8'h01, 2, 1'b0);
    run_op(8'h5A, 8'hC3, 5, 1'b0);
    run_op(8'h81, 8'h7F, 0, 1'b1);

    // Abort mid-CALC with reset
    beginsig = 1'b1;
    step();
    beginsig = 1'b0;
    locksig  = 1'b1;
    inbus    = 8'h37;
    step();
    locksig = 1'b0;
    inbus   = 8'h59;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_exp = 8'h00;
    chk("abort_outbus", {8'd0, outbus}, 16'd0);
    chk("abort_endsig", {15'd0, endsig}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort_quiet", {7'd0, endsig, outbus}, 16'd0);
    end
    run_op(8'h37, 8'h59, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
